// File: rtl/l1_line_refill_responder.sv
// Memory-side responder for the L1 cache: refills 8-byte lines one byte per beat
// from a variable-latency byte port and commits single-byte write-throughs.
module l1_line_refill_responder #(
  parameter int unsigned TamAddr    = 16,
  parameter int unsigned LINE_BYTES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_req,
  input  logic [TamAddr-1:0]        alloc_addr,
  input  logic                      wr_req,
  input  logic [TamAddr-1:0]        wr_addr,
  input  logic [7:0]                wr_byte,
  output logic [LINE_BYTES*8-1:0]   line_data,
  output logic [TamAddr-4:0]        line_addr,
  output logic                      dataComplete,
  output logic                      writeComplete,
  output logic                      busy,
  output logic [TamAddr-1:0]        mem_addr,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_ack
);

  localparam int unsigned BeatW = $clog2(LINE_BYTES);
  localparam int unsigned LineW = TamAddr - BeatW;
  localparam int unsigned DataW = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_RDONE = 3'd2,
    S_WRITE = 3'd3,
    S_WDONE = 3'd4
  } state_e;

  state_e               state_q;
  logic [BeatW-1:0]     beat_q;
  logic [DataW-1:0]     line_data_q;
  logic [LineW-1:0]     line_addr_q;
  logic [TamAddr-1:0]   mem_addr_q;
  logic [7:0]           mem_wdata_q;
  logic                 mem_rd_q;
  logic                 mem_wr_q;
  logic                 data_done_q;
  logic                 write_done_q;
  logic                 busy_q;

  // Byte offset of a refill request only selects the line; it never reaches memory.
  logic unused_alloc_offset;
  assign unused_alloc_offset = ^alloc_addr[BeatW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      line_data_q  <= '0;
      line_addr_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      data_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      case (state_q)
        // Write has priority so a refill cannot return data older than a pending write.
        S_IDLE: begin
          if (wr_req) begin
            state_q     <= S_WRITE;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= wr_addr;
            mem_wdata_q <= wr_byte;
            busy_q      <= 1'b1;
          end else if (alloc_req) begin
            state_q     <= S_READ;
            mem_rd_q    <= 1'b1;
            beat_q      <= '0;
            line_addr_q <= alloc_addr[TamAddr-1:BeatW];
            mem_addr_q  <= {alloc_addr[TamAddr-1:BeatW], BeatW'(0)};
            busy_q      <= 1'b1;
          end
        end
        S_READ: begin
          if (mem_ack) begin
            line_data_q[{beat_q, 3'b000} +: 8] <= mem_rdata;
            beat_q <= beat_q + BeatW'(1);
            if (beat_q == BeatW'(LINE_BYTES - 1)) begin
              state_q     <= S_RDONE;
              mem_rd_q    <= 1'b0;
              data_done_q <= 1'b1;
            end else begin
              mem_addr_q <= {line_addr_q, beat_q + BeatW'(1)};
            end
          end
        end
        S_RDONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_WRITE: begin
          if (mem_ack) begin
            state_q      <= S_WDONE;
            mem_wr_q     <= 1'b0;
            write_done_q <= 1'b1;
          end
        end
        S_WDONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign line_data     = line_data_q;
  assign line_addr     = line_addr_q;
  assign dataComplete  = data_done_q;
  assign writeComplete = write_done_q;
  assign busy          = busy_q;
  assign mem_addr      = mem_addr_q;
  assign mem_rd        = mem_rd_q;
  assign mem_wr        = mem_wr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_l1_line_refill_responder.sv
// Bench for l1_line_refill_responder: directed latency/priority/reset cases plus
// randomized traffic, checked every cycle against a transaction-level model.
module tb_l1_line_refill_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req = 1'b0;
  logic [15:0] alloc_addr = '0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_byte = '0;
  logic [63:0] line_data;
  logic [12:0] line_addr;
  logic        dataComplete, writeComplete, busy;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory image: low address byte, optionally scrambled with the high byte.
  bit xor_mode = 1'b0;
  assign mem_rdata = mem_addr[7:0] ^ (xor_mode ? mem_addr[15:8] : 8'h00);

  l1_line_refill_responder #(.TamAddr(16), .LINE_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_addr(alloc_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_byte(wr_byte),
    .line_data(line_data), .line_addr(line_addr),
    .dataComplete(dataComplete), .writeComplete(writeComplete), .busy(busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ (xor_mode ? a[15:8] : 8'h00);
  endfunction

  // Memory responder: 0 = ack tied high, 1 = random acks, 2 = scripted waits.
  int          ack_mode  = 0;
  int          wait_beat = 0;
  int          wait_n    = 0;
  int          hold      = 0;
  logic [15:0] prev_addr = '0;
  bit          prev_stb  = 1'b0;
  bit          prev_rd   = 1'b0;

  always @(posedge clk) begin
    #1;
    if ((mem_rd || mem_wr) && prev_stb && mem_addr == prev_addr && mem_rd == prev_rd) hold++;
    else hold = 0;
    prev_stb  = mem_rd || mem_wr;
    prev_addr = mem_addr;
    prev_rd   = mem_rd;
    case (ack_mode)
      0: mem_ack = 1'b1;
      1: mem_ack = ($urandom_range(0, 99) < 55);
      default: mem_ack = (mem_wr || (mem_rd && mem_addr[2:0] == 3'(wait_beat))) ? (hold >= wait_n) : 1'b1;
    endcase
  end

  // Transaction-level model: what the responder is doing, how many bytes have
  // arrived, and the line image built from the bench's own memory function.
  typedef enum {M_IDLE, M_RD, M_RDONE, M_WR, M_WDONE} mphase_e;
  mphase_e     m_st    = M_IDLE;
  int          m_cnt   = 0;
  logic [12:0] m_base  = '0;
  logic [63:0] m_line  = '0;
  logic [15:0] m_waddr = '0;
  logic [7:0]  m_wbyte = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = M_IDLE; m_cnt = 0; m_base = '0; m_line = '0;
    end else begin
      case (m_st)
        M_IDLE:
          if (wr_req) begin
            m_st = M_WR; m_waddr = wr_addr; m_wbyte = wr_byte;
          end else if (alloc_req) begin
            m_st = M_RD; m_base = alloc_addr[15:3]; m_cnt = 0;
          end
        M_RD:
          if (mem_ack) begin
            m_line[8*m_cnt +: 8] = mem_val({m_base, 3'(m_cnt)});
            m_cnt++;
            if (m_cnt == 8) begin m_st = M_RDONE; m_cnt = 0; end
          end
        M_WR:    if (mem_ack) m_st = M_WDONE;
        default: m_st = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, m_st != M_IDLE);
      chk("mem_rd", mem_rd, m_st == M_RD);
      chk("mem_wr", mem_wr, m_st == M_WR);
      chk("dataComplete", dataComplete, m_st == M_RDONE);
      chk("writeComplete", writeComplete, m_st == M_WDONE);
      chk("line_addr", line_addr, m_base);
      chk("strobe_overlap", mem_rd & mem_wr, 1'b0);
      if (m_st != M_RD) chk("line_data", line_data, m_line);
      if (m_st == M_RD) chk("rd_mem_addr", mem_addr, {m_base, 3'(m_cnt)});
      if (m_st == M_WR) begin
        chk("wr_mem_addr", mem_addr, m_waddr);
        chk("wr_mem_wdata", mem_wdata, m_wbyte);
      end
    end
  end

  // Called just after the accepting edge; counts cycles until the wanted pulse.
  task automatic wait_pulse(input bit want_data, input logic [15:0] probe, output int lat,
                            output int probe_cyc, output int rd_cyc, output int wr_cyc);
    lat = 0; probe_cyc = 0; rd_cyc = 0; wr_cyc = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      if (mem_rd && mem_addr == probe) probe_cyc++;
      if (want_data ? dataComplete : writeComplete) break;
      if (lat >= 400) begin
        n_tests++; n_fail++;
        $display("FAIL pulse_timeout: no completion after %0d cycles, expected one", lat);
        break;
      end
    end
  endtask

  task automatic drop_reqs(input bit a, input bit w);
    @(posedge clk); #1;
    if (a) alloc_req = 1'b0;
    if (w) wr_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pc, rc, wc, lat_w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_line_data", line_data, 64'h0);
    chk("rst_line_addr", line_addr, 13'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Plain refill with ack tied high.
    ack_mode = 0;
    alloc_addr = 16'h01A5; alloc_req = 1'b1;
    @(posedge clk);
    wait_pulse(1'b1, 16'h01A3, lat, pc, rc, wc);
    chk("t1_latency", lat, 9);
    chk("t1_line_data", line_data, 64'hA7A6A5A4A3A2A1A0);
    chk("t1_line_addr", line_addr, 13'h034);
    drop_reqs(1'b1, 1'b0);
    @(negedge clk);
    chk("t1_pulse_width", dataComplete, 1'b0);

    // Two wait cycles on beat 3.
    ack_mode = 2; wait_beat = 3; wait_n = 2;
    @(posedge clk); #1 alloc_req = 1'b1;
    @(posedge clk);
    wait_pulse(1'b1, 16'h01A3, lat, pc, rc, wc);
    chk("t2_latency", lat, 11);
    chk("t2_beat3_hold", pc, 3);
    chk("t2_line_data", line_data, 64'hA7A6A5A4A3A2A1A0);
    drop_reqs(1'b1, 1'b0);

    // Write with one wait cycle.
    wait_n = 1;
    @(posedge clk); #1 wr_addr = 16'h0042; wr_byte = 8'h5C; wr_req = 1'b1;
    @(posedge clk);
    wait_pulse(1'b0, 16'hFFFF, lat, pc, rc, wc);
    chk("t3_latency", lat, 3);
    chk("t3_wr_cycles", wc, 2);
    chk("t3_rd_cycles", rc, 0);
    drop_reqs(1'b0, 1'b1);

    // Simultaneous requests: write first, then the refill.
    ack_mode = 1;
    @(posedge clk); #1;
    alloc_addr = 16'h03F0; wr_addr = 16'h03F2; wr_byte = 8'hE1;
    alloc_req = 1'b1; wr_req = 1'b1;
    @(posedge clk);
    wait_pulse(1'b0, 16'hFFFF, lat_w, pc, rc, wc);
    chk("t4_write_first", writeComplete, 1'b1);
    chk("t4_no_read_before_write", rc, 0);
    drop_reqs(1'b0, 1'b1);
    wait_pulse(1'b1, 16'hFFFF, lat, pc, rc, wc);
    chk("t4_read_done", dataComplete, 1'b1);
    chk("t4_no_write_during_read", wc, 0);
    chk("t4_line_data", line_data, 64'hF7F6F5F4F3F2F1F0);
    chk("t4_line_addr", line_addr, 13'h07E);
    drop_reqs(1'b1, 1'b0);

    // Reset during beat 5, then restart with the request still held.
    ack_mode = 0;
    @(posedge clk); #1 alloc_addr = 16'h01A5; alloc_req = 1'b1;
    @(posedge clk);
    repeat (6) @(negedge clk);
    chk("t5_beat5_addr", mem_addr, 16'h01A5);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_mem_rd", mem_rd, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_line_data", line_data, 64'h0);
    chk("t5_rst_line_addr", line_addr, 13'h0);
    chk("t5_rst_mem_addr", mem_addr, 16'h0);
    chk("t5_rst_dataComplete", dataComplete, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    wait_pulse(1'b1, 16'h01A0, lat, pc, rc, wc);
    chk("t5_restart_latency", lat, 9);
    chk("t5_restart_beat0", pc, 1);
    chk("t5_line_data", line_data, 64'hA7A6A5A4A3A2A1A0);
    drop_reqs(1'b1, 1'b0);

    // Stray acks while idle, then alloc_addr moves mid-fill.
    ack_mode = 1;
    repeat (10) begin
      @(negedge clk);
      chk("t6_idle_busy", busy, 1'b0);
    end
    @(posedge clk); #1 alloc_addr = 16'h0B17; alloc_req = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    alloc_addr = 16'hFFFF;
    wait_pulse(1'b1, 16'hFFFF, lat, pc, rc, wc);
    chk("t6_line_addr", line_addr, 13'h162);
    chk("t6_line_data", line_data, 64'h1716151413121110);
    drop_reqs(1'b1, 1'b0);

    // Randomized traffic against the model.
    xor_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      ack_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      @(posedge clk); #1;
      alloc_addr = 16'($urandom);
      wr_addr    = 16'($urandom);
      wr_byte    = 8'($urandom);
      case (kind)
        0: repeat ($urandom_range(1, 5)) @(posedge clk);
        1: begin
          alloc_req = 1'b1;
          @(posedge clk);
          if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            alloc_addr = 16'($urandom);
          end
          wait_pulse(1'b1, 16'hFFFF, lat, pc, rc, wc);
          drop_reqs(1'b1, 1'b0);
        end
        2: begin
          wr_req = 1'b1;
          @(posedge clk);
          wait_pulse(1'b0, 16'hFFFF, lat, pc, rc, wc);
          drop_reqs(1'b0, 1'b1);
        end
        default: begin
          alloc_req = 1'b1; wr_req = 1'b1;
          @(posedge clk);
          wait_pulse(1'b0, 16'hFFFF, lat, pc, rc, wc);
          chk("rnd_read_after_write", rc, 0);
          drop_reqs(1'b0, 1'b1);
          wait_pulse(1'b1, 16'hFFFF, lat, pc, rc, wc);
          drop_reqs(1'b1, 1'b0);
        end
      endcase
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_line_refill_responder.md
Name: l1_line_refill_responder

Overview:
- Memory-side responder for the L1 split data/instruction cache controller.
- Services the cache's allocate (line refill) and write requests against a byte-wide backing memory port with variable latency.
- Assembles 8-byte lines and returns them with a one-cycle dataComplete pulse; acknowledges writes with a one-cycle writeComplete pulse.

Parameters:
- TamAddr, 16: byte address width; line base = address[TamAddr-1:3]
- LINE_BYTES, 8: bytes per line; fixed at 8, and the beat counter is 3 bits

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  level; cache requests a line fill; held until dataComplete
- alloc_addr  in  TamAddr  any byte address inside the requested line
- wr_req  in  1  level; cache requests a byte write-through; held until writeComplete
- wr_addr  in  TamAddr  byte address to write
- wr_byte  in  8  byte to write
- line_data  out  64  assembled line; byte k on bits [8k+7:8k], matching address[2:0]
- line_addr  out  TamAddr-3  line base of line_data
- dataComplete  out  1  one-cycle pulse; line_data/line_addr valid
- writeComplete  out  1  one-cycle pulse; write committed
- busy  out  1  high in every state except IDLE
- mem_addr  out  TamAddr  backing memory byte address
- mem_rd  out  1  read strobe, held until mem_ack
- mem_wr  out  1  write strobe, held until mem_ack
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid when mem_ack is high
- mem_ack  in  1  completes the current beat

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; beat counter = 0.
  - line_data, line_addr, mem_addr and mem_wdata = 0.
  - All strobes and pulses = 0.
  - A partial line is discarded and no completion pulse is issued.
- States and transitions:
  - IDLE: wr_req → WRITE; else alloc_req → READ. If both are high, the write wins so a refill never returns stale data for a pending write. Neither → stay in IDLE.
  - READ: mem_rd = 1; mem_addr = {alloc_addr[TamAddr-1:3], beat}. On mem_ack, store mem_rdata in byte lane beat and increment beat. An ack on beat 7 → RDONE and beat wraps to 0.
  - RDONE: dataComplete = 1 for exactly one cycle → IDLE.
  - WRITE: mem_wr = 1; mem_addr = wr_addr; mem_wdata = wr_byte. On mem_ack → WDONE.
  - WDONE: writeComplete = 1 for exactly one cycle → IDLE.
- Address and data capture:
  - alloc_addr is captured into line_addr on entry to READ. Later changes to alloc_addr during the fill are ignored.
  - line_data holds its last completed value until the next READ begins.
  - During a fill, line_data bytes update lane by lane. Bytes are only valid when dataComplete is high.
- Request handling:
  - Requests are sampled only in IDLE. Requests arriving while busy are ignored until the block returns to IDLE. A request still held high in IDLE is then serviced.
  - mem_ack in IDLE, RDONE or WDONE is ignored.
  - mem_rd and mem_wr are never high at the same time.
- Latency with mem_ack tied high (request accepted at edge E0):
  - READ occupies cycles 1–8; dataComplete rises in cycle 9.
  - writeComplete rises in cycle 2.
  - Each wait cycle on a beat adds one cycle.
- Requester contract: the cache drops alloc_req/wr_req in the cycle after the pulse. The mandatory DONE → IDLE step prevents re-triggering the same request.

Test Plan:
- Reset, then alloc_req with alloc_addr=16'h1A5, mem_ack tied high, memory byte = low byte of address → mem_addr steps 16'h1A0..16'h1A7; line_data = 64'hA7A6A5A4A3A2A1A0; line_addr = 13'h034; dataComplete pulses one cycle, 9 cycles after acceptance.
- Same fill with 2 wait cycles on beat 3 → mem_rd and mem_addr=16'h1A3 held 3 cycles; dataComplete at cycle 11; line_data unchanged from the previous case.
- wr_req with wr_addr=16'h0042, wr_byte=8'h5C, ack after 1 wait → mem_wr/mem_wdata=8'h5C held 2 cycles; writeComplete pulses at cycle 3; mem_rd stays 0.
- alloc_req and wr_req rise together → write serviced first, writeComplete; then the read starts from IDLE and completes with dataComplete; no overlap of strobes.
- Assert rst during beat 5 of a fill → outputs 0 immediately, no dataComplete; after release with alloc_req still high, the fill restarts at beat 0 and completes normally.
- mem_ack pulses while idle, and alloc_addr changes mid-fill → no state change while idle; line_addr keeps the value captured at start.
